uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Oversampling UART receiver that sits directly downstream of the baud tick generator.
- Consumes its 1-clock `tick` strobe (TICKS_PER_BIT ticks per bit) and synchronises the asynchronous serial `rx` line.
- Detects and validates the start bit, samples each bit at mid-bit, checks optional parity and the stop bit.
- Presents each received byte on a valid/ready interface with a one-entry holding register.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9), LSB first
- TICKS_PER_BIT, 16, tick strobes per bit period; even, >= 4
- PARITY_EN, 0, 1 = one parity bit follows the data bits
- PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN = 0

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- tick  in  1  oversample strobe from the baud generator, 1-clock pulse
- rx  in  1  asynchronous serial input, idle high
- rx_data  out  DATA_BITS  received data word
- rx_valid  out  1  rx_data holds an unconsumed word
- rx_ready  in  1  consumer accepts the word when rx_valid && rx_ready
- frame_err  out  1  1-clock pulse: stop bit sampled low
- parity_err  out  1  1-clock pulse: parity mismatch
- overrun  out  1  1-clock pulse: frame completed while the holding register was full and not being drained

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-low.
  - While rst_n = 0 at a clk edge: state = IDLE, tick counter = 0, bit counter = 0, shift register = 0.
  - Synchroniser flops are set to 1.
  - rx_data = 0, rx_valid = 0; frame_err, parity_err and overrun = 0.
  - Reset mid-frame abandons the frame with no error pulses.
- Input path:
  - 2-flop synchroniser; rx_s is the second flop output.
  - The state machine uses only rx_s, so there are 2 clocks of latency from rx.
- Counters:
  - Tick counter is $clog2(TICKS_PER_BIT) bits and advances only on clocks with tick = 1.
  - Bit counter is $clog2(DATA_BITS+1) bits.
- IDLE:
  - rx_s = 0 moves to START and clears the tick counter; this check is made on any clock, not only on tick clocks.
- START:
  - On the tick where the tick counter reaches TICKS_PER_BIT/2 - 1, sample rx_s (mid start bit).
  - rx_s = 0: go to DATA and clear both counters.
  - rx_s = 1: glitch; return to IDLE silently with no pulses.
- DATA:
  - On each tick where the tick counter reaches TICKS_PER_BIT - 1: shift rx_s into the MSB end (LSB first on the wire), clear the tick counter, increment the bit counter.
  - After DATA_BITS samples, go to PARITY if PARITY_EN = 1, else to STOP.
- PARITY:
  - Sample after TICKS_PER_BIT ticks.
  - Latch mismatch = (XOR of data bits ^ sample) != PARITY_ODD.
- STOP:
  - Sample after TICKS_PER_BIT ticks, on clock N.
  - rx_s = 1 and no parity mismatch: word complete; go to IDLE.
  - rx_s = 1 and parity mismatch: parity_err = 1 on clock N+1; word discarded; go to IDLE.
  - rx_s = 0: frame_err = 1 on clock N+1; word discarded, including any parity result; go to BREAK.
- BREAK:
  - Stay until rx_s = 1, then go to IDLE. This prevents a held-low line from retriggering.
- Delivery of a complete word (registered on clock N+1):
  - rx_valid = 0: load rx_data; rx_valid = 1.
  - rx_valid = 1 and rx_ready = 1 on clock N: old word consumed and new word loaded in the same cycle; rx_valid stays 1; no overrun.
  - rx_valid = 1 and rx_ready = 0: new word dropped, rx_data unchanged, overrun = 1 for one clock.
  - Otherwise rx_valid falls on the clock after rx_valid && rx_ready.
  - rx_data is stable while rx_valid = 1.
- Tick and error timing:
  - A tick coincident with the IDLE->START transition is not counted.
  - Error pulses are mutually exclusive per frame; at most one of frame_err, parity_err, overrun fires per frame.

Decomposition:
- Shared package uart_pkg:
  - state enum type uart_rx_state_e (IDLE, START, DATA, PARITY, STOP, BREAK)
  - default DATA_BITS and TICKS_PER_BIT localparams, shared with the TX side
- Sub-module uart_sync_2ff:
  - parameterised reset value, synchronous active-low reset
  - reused by future TX/flow-control inputs

Test Plan:
All scenarios use TICKS_PER_BIT = 16, tick every 4 clocks, DATA_BITS = 8 unless noted.
- 0xA5 frame with rx_ready held 1 -> rx_valid pulses 1 clock with rx_data = 0xA5; no error pulses; valid rises 1 clock after the stop sample.
- 0x3C then 0xC3 back-to-back with rx_ready = 0 throughout -> rx_data stays 0x3C, rx_valid stays 1, overrun pulses once at the second stop sample.
  - Then assert rx_ready -> rx_valid falls next clock.
- rx low for 5 ticks then high (glitch) -> returns to IDLE; no rx_valid, no error.
  - A following valid 0x55 frame -> received correctly.
- 0xFF with stop bit driven 0, then line held low 3 bit times -> frame_err single pulse, no rx_valid, state BREAK until rx high.
  - Next frame 0x01 -> received correctly.
- PARITY_EN = 1, PARITY_ODD = 0: 0x07 with parity bit 1 -> accepted.
  - Same frame with parity bit 0 -> parity_err pulse, no rx_valid.
- rst_n low for 1 clock midway through DATA of 0x81 -> all outputs 0, state IDLE.
  - Subsequent 0x81 frame -> rx_data = 0x81 with no stale bits.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame shape.
// Imported by both the RX and TX sides.
package uart_pkg;

  localparam int DATA_BITS_DEF     = 8;
  localparam int TICKS_PER_BIT_DEF = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_rx_state_e;

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchroniser for asynchronous single-bit inputs.
// Both flops reset to RST_VAL so an idle line reads as idle straight out of reset.
module uart_sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit validation, mid-bit sampling,
// optional parity, stop check and a one-entry valid/ready holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS     = DATA_BITS_DEF,
  parameter int TICKS_PER_BIT = TICKS_PER_BIT_DEF,
  parameter int PARITY_EN     = 0,
  parameter int PARITY_ODD    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int TW = $clog2(TICKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] T_MID  = TW'(TICKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_END  = TW'(TICKS_PER_BIT - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic          ODD    = (PARITY_ODD != 0);

  logic                 rx_s;
  uart_rx_state_e       state;
  logic [TW-1:0]        tcnt;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad;
  logic                 mid_hit;
  logic                 end_hit;
  logic                 word_done;

  uart_sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx),
    .q    (rx_s)
  );

  assign mid_hit   = tick && (tcnt == T_MID);
  assign end_hit   = tick && (tcnt == T_END);
  assign word_done = (state == STOP) && end_hit && rx_s && !par_bad;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      tcnt       <= '0;
      bcnt       <= '0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      if (tick) tcnt <= tcnt + 1'b1;

      unique case (state)
        IDLE: begin
          // Edge check runs every clock; a coincident tick is discarded.
          if (!rx_s) begin
            state   <= START;
            tcnt    <= '0;
            par_bad <= 1'b0;
          end
        end
        START: begin
          if (mid_hit) begin
            tcnt <= '0;
            if (!rx_s) begin
              state <= DATA;
              bcnt  <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (end_hit) begin
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            tcnt  <= '0;
            bcnt  <= bcnt + 1'b1;
            if (bcnt == B_LAST)
              state <= (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (end_hit) begin
            tcnt    <= '0;
            par_bad <= ((^shreg) ^ rx_s) != ODD;
            state   <= STOP;
          end
        end
        STOP: begin
          if (end_hit) begin
            tcnt <= '0;
            if (!rx_s) begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end else begin
              parity_err <= par_bad;
              state      <= IDLE;
            end
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (word_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 16 ticks/bit, tick every 4 clocks,
// one plain 8N1 instance and one even-parity instance.
module tb_uart_rx;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       rx = 1'b1;
  logic       rx_p = 1'b1;
  logic       rx_ready = 1'b0;
  logic       rx_ready_p = 1'b1;
  logic [7:0] rx_data, rx_data_p;
  logic       rx_valid, rx_valid_p;
  logic       frame_err, parity_err, overrun;
  logic       frame_err_p, parity_err_p, overrun_p;

  int nchk = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  uart_rx #(
    .DATA_BITS(8), .TICKS_PER_BIT(16),
    .PARITY_EN(0), .PARITY_ODD(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
  );

  uart_rx #(
    .DATA_BITS(8), .TICKS_PER_BIT(16),
    .PARITY_EN(1), .PARITY_ODD(0)
  ) dut_p (
    .clk(clk), .rst_n(rst_n), .tick(tick), .rx(rx_p),
    .rx_data(rx_data_p), .rx_valid(rx_valid_p), .rx_ready(rx_ready_p),
    .frame_err(frame_err_p), .parity_err(parity_err_p), .overrun(overrun_p)
  );

  initial begin
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      tick = (n % 4 == 0);
    end
  end

  // Event counters; tests work on differences of snapshots.
  int         cyc = 0, nval = 0, vcyc = 0, nferr = 0, nperr = 0, novr = 0;
  int         rise_cyc = 0;
  logic [7:0] last_data = '0;
  logic       pv = 1'b0;
  int         nval_p = 0, nferr_p = 0, nperr_p = 0;
  logic [7:0] last_p = '0;
  logic       ppv = 1'b0;

  always @(negedge clk) begin
    cyc   <= cyc + 1;
    pv    <= rx_valid;
    ppv   <= rx_valid_p;
    vcyc  <= vcyc + int'(rx_valid);
    nferr <= nferr + int'(frame_err);
    nperr <= nperr + int'(parity_err);
    novr  <= novr + int'(overrun);
    nferr_p <= nferr_p + int'(frame_err_p);
    nperr_p <= nperr_p + int'(parity_err_p);
    if (rx_valid && !pv) begin
      nval      <= nval + 1;
      last_data <= rx_data;
      rise_cyc  <= cyc;
    end
    if (rx_valid_p && !ppv) begin
      nval_p <= nval_p + 1;
      last_p <= rx_data_p;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic b, input bit to_p);
    if (to_p) rx_p = b;
    else rx = b;
    repeat (64) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pe,
                            input logic pb, input logic sb, input bit to_p);
    drive(1'b0, to_p);
    for (int i = 0; i < 8; i++) drive(d[i], to_p);
    if (pe) drive(pb, to_p);
    drive(sb, to_p);
  endtask

  typedef struct {
    logic [7:0] d;
    int         e_val;
    int         e_vcyc;
  } vec_t;

  // Sends one good 8N1 frame with rx_ready = 1 and checks the result.
  task automatic run_vec(input vec_t v, input string tag);
    int s_val, s_vcyc, s_ferr, s_perr, s_ovr, t0, lat;
    rx_ready = 1'b1;
    s_val = nval; s_vcyc = vcyc; s_ferr = nferr;
    s_perr = nperr; s_ovr = novr;
    t0 = cyc;
    send_frame(v.d, 1'b0, 1'b0, 1'b1, 1'b0);
    rx = 1'b1;
    repeat (128) @(negedge clk);
    check({tag, "/nvalid"}, nval - s_val, v.e_val);
    check({tag, "/data"}, int'(last_data), int'(v.d));
    check({tag, "/vcycles"}, vcyc - s_vcyc, v.e_vcyc);
    check({tag, "/errs"}, (nferr - s_ferr) + (nperr - s_perr) + (novr - s_ovr), 0);
    lat = rise_cyc - t0;
    check({tag, "/latency_ok"}, int'(lat >= 600 && lat <= 624), 1);
  endtask

  vec_t vecs[5];
  int s_val, s_ferr, s_ovr, s_perr;

  initial begin
    vecs[0] = '{d: 8'hA5, e_val: 1, e_vcyc: 1};
    vecs[1] = '{d: 8'h5A, e_val: 1, e_vcyc: 1};
    vecs[2] = '{d: 8'h00, e_val: 1, e_vcyc: 1};
    vecs[3] = '{d: 8'hFF, e_val: 1, e_vcyc: 1};
    vecs[4] = '{d: 8'h80, e_val: 1, e_vcyc: 1};

    repeat (5) @(negedge clk);
    check("rst/valid", int'(rx_valid), 0);
    check("rst/data", int'(rx_data), 0);
    check("rst/pulses", int'({frame_err, parity_err, overrun}), 0);
    check("rst/state", int'(dut.state), int'(IDLE));
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back frames into a full holding register.
    rx_ready = 1'b0;
    s_val = nval; s_ovr = novr; s_ferr = nferr;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0);
    rx = 1'b1;
    repeat (64) @(negedge clk);
    check("ovr/count", novr - s_ovr, 1);
    check("ovr/nvalid", nval - s_val, 1);
    check("ovr/valid", int'(rx_valid), 1);
    check("ovr/data", int'(rx_data), 'h3C);
    check("ovr/ferr", nferr - s_ferr, 0);
    rx_ready = 1'b1;
    @(negedge clk);
    check("ovr/drain", int'(rx_valid), 0);

    // Start-bit glitch of 5 ticks.
    s_val = nval; s_ferr = nferr;
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (128) @(negedge clk);
    check("glitch/nvalid", nval - s_val, 0);
    check("glitch/ferr", nferr - s_ferr, 0);
    check("glitch/state", int'(dut.state), int'(IDLE));
    run_vec('{d: 8'h55, e_val: 1, e_vcyc: 1}, "after_glitch");

    // Stop bit low, then line held low.
    s_val = nval; s_ferr = nferr; s_ovr = novr;
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (192) @(negedge clk);
    check("brk/ferr", nferr - s_ferr, 1);
    check("brk/nvalid", nval - s_val, 0);
    check("brk/state", int'(dut.state), int'(BREAK));
    check("brk/ovr", novr - s_ovr, 0);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    check("brk/idle", int'(dut.state), int'(IDLE));
    run_vec('{d: 8'h01, e_val: 1, e_vcyc: 1}, "after_brk");

    // Even parity: 0x07 has three ones, so the parity bit must be 1.
    s_val = nval_p; s_perr = nperr_p;
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b1);
    rx_p = 1'b1;
    repeat (128) @(negedge clk);
    check("par_ok/nvalid", nval_p - s_val, 1);
    check("par_ok/data", int'(last_p), 'h07);
    check("par_ok/perr", nperr_p - s_perr, 0);
    s_val = nval_p; s_perr = nperr_p; s_ferr = nferr_p;
    send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b1);
    rx_p = 1'b1;
    repeat (128) @(negedge clk);
    check("par_bad/perr", nperr_p - s_perr, 1);
    check("par_bad/nvalid", nval_p - s_val, 0);
    check("par_bad/ferr", nferr_p - s_ferr, 0);

    // Reset in the middle of DATA with a word still held.
    rx_ready = 1'b0;
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
    rx = 1'b1;
    repeat (64) @(negedge clk);
    check("rstmid/held", int'(rx_valid), 1);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    repeat (30) @(negedge clk);
    check("rstmid/in_data", int'(dut.state), int'(DATA));
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmid/valid", int'(rx_valid), 0);
    check("rstmid/data", int'(rx_data), 0);
    check("rstmid/pulses", int'({frame_err, parity_err, overrun}), 0);
    check("rstmid/state", int'(dut.state), int'(IDLE));
    rst_n = 1'b1;
    rx = 1'b1;
    repeat (200) @(negedge clk);
    run_vec('{d: 8'h81, e_val: 1, e_vcyc: 1}, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
